core_line_requester: RTL and testbench

Core-side initiator for the core/cache request bus. It turns single-cycle line read and line write commands from the core pipeline into the multi-beat `reqcyc`/`reqack` and `respcyc`/`respack` handshakes that the cache side answers. It sits between the fetch/LSU logic and the cache port.

- Transfers are one 64-byte line (8 × 64-bit beats).
- One transaction is outstanding at a time.

---
 rtl/core_bus_pkg.sv | 33 +++
 rtl/core_line_requester_if.sv | 28 ++
 rtl/line_beat_buffer.sv | 40 ++++
 rtl/core_line_requester.sv | 140 ++++++++++++++
 tb/tb_core_line_requester.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_bus_pkg.sv
// Shared definitions for the core/cache request bus: tag layout, field
// encodings, line geometry and the line requester state encoding.
package core_bus_pkg;

    localparam int BEATS = 8;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [3:0] MEMORY = 4'b0001;
    localparam logic [3:0] MMIO   = 4'b0010;
    localparam logic [3:0] PORT   = 4'b0100;
    localparam logic [3:0] IRQ    = 4'b1000;

    localparam logic DATA  = 1'b1;
    localparam logic INSTR = 1'b0;

    // 13-bit tag as it appears on reqtag/resptag.
    typedef struct packed {
        logic       rw;
        logic [3:0] ttype;
        logic       kind;
        logic [6:0] seq;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WDATA = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/core_line_requester_if.sv
// Core/cache request bus: request channel (core -> cache) and response
// channel (cache -> core), each with its own valid/accept pair.
interface core_line_requester_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    // A beat transfers on a rising edge where the source's valid (reqcyc or
    // respcyc) and the sink's accept (reqack or respack) are both high; while
    // valid is high and not yet accepted the source holds data and tag stable.
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqcyc;
    logic                  reqack;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respcyc;
    logic                  respack;

    modport master (
        output req, reqtag, reqcyc, respack,
        input  reqack, resp, resptag, respcyc
    );

    modport slave (
        input  req, reqtag, reqcyc, respack,
        output reqack, resp, resptag, respcyc
    );
endinterface

// File: rtl/line_beat_buffer.sv
// BEATS x DATA_WIDTH register file: whole-line load, single-beat write,
// single-beat read mux and flat whole-line view.
module line_beat_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8,
    parameter int IDX_W      = $clog2(BEATS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [DATA_WIDTH*BEATS-1:0] line_in,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [DATA_WIDTH*BEATS-1:0] line_out
);

    logic [DATA_WIDTH-1:0] mem [BEATS];

    // Load has priority so a new transaction never mixes with a stale beat write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BEATS; i++) mem[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < BEATS; i++) mem[i] <= line_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    always_comb begin
        line_out = '0;
        for (int i = 0; i < BEATS; i++) line_out[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end

endmodule

// File: rtl/core_line_requester.sv
// Core-side line read/write initiator for the core/cache request bus.
// Define CORE_REQ_TAGCHECK_EN to drop (and flag) response beats with a wrong tag.
module core_line_requester
    import core_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int BEATS      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_req,
    input  logic                        wr_req,
    input  logic                        kind,
    input  logic [63:0]                 addr,
    input  logic [DATA_WIDTH*BEATS-1:0] wr_line,
    output logic                        busy,
    output logic                        rd_done,
    output logic [DATA_WIDTH*BEATS-1:0] rd_line,
    output logic                        wr_done,
    output logic                        tag_err,
    output state_t                      dbg_state,
    core_line_requester_if.master       bus
);

    localparam int CW = $clog2(BEATS);
    localparam int LW = DATA_WIDTH * BEATS;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [6:0]            seq;
    tag_t                  tag_q;
    logic [63:0]           addr_q;
    logic                  rd_done_q, wr_done_q, tag_err_q;
    logic                  cmd_rd, cmd_wr, last, tag_ok, beat_take, wbeat_take;
    logic [DATA_WIDTH-1:0] wbuf_beat, rbuf_beat;
    logic [LW-1:0]         wbuf_line;
    logic                  unused_bits;

    // A simultaneous read and write resolves to the read; the core keeps wr_req up.
    assign cmd_rd     = (state == S_IDLE) && rd_req;
    assign cmd_wr     = (state == S_IDLE) && !rd_req && wr_req;
    assign last       = (cnt == CW'(BEATS - 1));
    assign wbeat_take = (state == S_WDATA) && bus.reqack;
    assign beat_take  = (state == S_RESP) && bus.respcyc && tag_ok;

`ifdef CORE_REQ_TAGCHECK_EN
    assign tag_ok      = (bus.resptag == TAG_WIDTH'(tag_q));
    assign unused_bits = ^{addr[5:0], wbuf_line, rbuf_beat};
`else
    assign tag_ok      = 1'b1;
    assign unused_bits = ^{addr[5:0], wbuf_line, rbuf_beat, bus.resptag};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_rd || cmd_wr) state_nx = S_ADDR;
            S_ADDR:  if (bus.reqack) state_nx = (tag_q.rw == READ) ? S_RESP : S_WDATA;
            S_WDATA: if (bus.reqack && last) state_nx = S_IDLE;
            S_RESP:  if (beat_take && last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        bus.reqcyc  = (state == S_ADDR) || (state == S_WDATA);
        bus.respack = (state == S_RESP) && bus.respcyc;
        bus.reqtag  = busy ? TAG_WIDTH'(tag_q) : '0;
        bus.req     = '0;
        case (state)
            S_ADDR:  bus.req = DATA_WIDTH'(addr_q);
            S_WDATA: bus.req = wbuf_beat;
            default: bus.req = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            seq       <= '0;
            tag_q     <= '0;
            addr_q    <= '0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            tag_err_q <= 1'b0;
        end else begin
            rd_done_q <= beat_take && last;
            wr_done_q <= wbeat_take && last;
            tag_err_q <= (state == S_RESP) && bus.respcyc && !tag_ok;
            if (cmd_rd || cmd_wr) begin
                addr_q <= {addr[63:6], 6'b0};
                tag_q  <= '{rw: (cmd_rd ? READ : WRITE), ttype: MEMORY, kind: kind, seq: seq};
                seq    <= seq + 7'd1;
                cnt    <= '0;
            end else if (wbeat_take || beat_take) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rd_done   = rd_done_q;
    assign wr_done   = wr_done_q;
    assign tag_err   = tag_err_q;
    assign dbg_state = state;

    line_beat_buffer #(.DATA_WIDTH(DATA_WIDTH), .BEATS(BEATS)) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .load     (cmd_wr),
        .line_in  (wr_line),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_data  ('0),
        .rd_idx   (cnt),
        .rd_data  (wbuf_beat),
        .line_out (wbuf_line)
    );

    // Read assembly buffer is zeroed when a read starts so no beats of an older line survive.
    line_beat_buffer #(.DATA_WIDTH(DATA_WIDTH), .BEATS(BEATS)) u_rbuf (
        .clk      (clk),
        .reset    (reset),
        .load     (cmd_rd),
        .line_in  ('0),
        .wr_en    (beat_take),
        .wr_idx   (cnt),
        .wr_data  (bus.resp),
        .rd_idx   ('0),
        .rd_data  (rbuf_beat),
        .line_out (rd_line)
    );

endmodule

// File: tb/tb_core_line_requester.sv
// Directed scoreboard bench for core_line_requester: stimulus pushes expected
// request beats, lines and pulses; a negedge monitor pops and compares them.
module tb_core_line_requester;
    import core_bus_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req, wr_req, kind;
    logic [63:0]  addr;
    logic [511:0] wr_line;
    logic         busy, rd_done, wr_done, tag_err;
    logic [511:0] rd_line;
    state_t       dbg_state;

    core_line_requester_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

    core_line_requester dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .kind      (kind),
        .addr      (addr),
        .wr_line   (wr_line),
        .busy      (busy),
        .rd_done   (rd_done),
        .rd_line   (rd_line),
        .wr_done   (wr_done),
        .tag_err   (tag_err),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int cmd_cyc = 0;
    logic [12:0]  cur_tag;
    logic [76:0]  exp_req_q[$];
    logic [511:0] exp_rd_q[$];
    logic         exp_wr_q[$];
    logic         exp_err_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: request beats are checked every valid cycle (stability under stall)
    // and popped on accept; completion pulses pop their own queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.reqcyc) begin
                if (exp_req_q.size() == 0) chk("req_unexpected", {bus.reqtag, bus.req}, '0);
                else begin
                    chk("req_beat", {bus.reqtag, bus.req}, exp_req_q[0]);
                    if (bus.reqack) void'(exp_req_q.pop_front());
                end
            end
            if (rd_done) begin
                if (exp_rd_q.size() == 0) chk("rd_done_unexpected", rd_done, 1'b0);
                else chk("rd_line", rd_line, exp_rd_q.pop_front());
            end
            if (wr_done) begin
                if (exp_wr_q.size() == 0) chk("wr_done_unexpected", wr_done, 1'b0);
                else chk("wr_done", wr_done, exp_wr_q.pop_front());
            end
            if (tag_err) begin
                if (exp_err_q.size() == 0) chk("tag_err_unexpected", tag_err, 1'b0);
                else chk("tag_err", tag_err, exp_err_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic rd, input logic wr, input logic [63:0] a, input logic k,
                            input logic [511:0] wl, input logic [63:0] exp_abeat,
                            input logic [12:0] exp_tag, input logic [511:0] exp_line);
        rd_req  = rd;
        wr_req  = wr;
        addr    = a;
        kind    = k;
        wr_line = wl;
        exp_req_q.push_back({exp_tag, exp_abeat});
        if (rd) begin
            exp_rd_q.push_back(exp_line);
            cur_tag = exp_tag;
        end else begin
            for (int i = 0; i < 8; i++) exp_req_q.push_back({exp_tag, exp_line[64*i +: 64]});
            exp_wr_q.push_back(1'b1);
        end
        @(negedge clk);
        chk("cmd_in_idle", {busy, dbg_state}, {1'b0, S_IDLE});
        cmd_cyc = cyc_cnt;
        step();
        rd_req = 1'b0;
        if (!rd) wr_req = 1'b0;
    endtask

    // n request beats; beat index sa_idx/sb_idx is stalled for sa_len/sb_len cycles.
    task automatic run_req(input int n, input int sa_idx, input int sa_len, input int sb_idx, input int sb_len);
        int st;
        if (n > 1) begin
            bus.respcyc = 1'b1;
            bus.resp    = 64'hDEAD_DEAD_DEAD_DEAD;
            bus.resptag = 13'h1fff;
        end
        for (int b = 0; b < n; b++) begin
            st = (b == sa_idx) ? sa_len : (b == sb_idx) ? sb_len : 0;
            bus.reqack = 1'b0;
            for (int s = 0; s < st; s++) begin
                @(negedge clk);
                chk("stall_ctl", {busy, bus.reqcyc, bus.respack}, 3'b110);
                step();
            end
            bus.reqack = 1'b1;
            @(negedge clk);
            chk("req_ctl", {busy, bus.reqcyc, bus.respack}, 3'b110);
            step();
        end
        bus.reqack  = 1'b0;
        bus.respcyc = 1'b0;
    endtask

    task automatic run_resp(input logic [511:0] line, input logic bad, input int gap_idx, input int gap_len);
`ifdef CORE_REQ_TAGCHECK_EN
        if (bad) begin
            bus.resp    = 64'hBAD0_BAD0_BAD0_BAD0;
            bus.resptag = cur_tag ^ 13'h1;
            bus.respcyc = 1'b1;
            exp_err_q.push_back(1'b1);
            @(negedge clk);
            chk("bad_beat_acked", {busy, bus.respack}, 2'b11);
            step();
        end
`endif
        for (int b = 0; b < 8; b++) begin
            bus.respcyc = 1'b0;
            if (b == gap_idx) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("gap_ctl", {busy, bus.respack, rd_done}, 3'b100);
                    step();
                end
            end
            bus.resp    = line[64*b +: 64];
            bus.resptag = cur_tag;
`ifndef CORE_REQ_TAGCHECK_EN
            if (bad && b == 0) bus.resptag = cur_tag ^ 13'h1;
`endif
            bus.respcyc = 1'b1;
            @(negedge clk);
            chk("resp_ctl", {busy, bus.respack, rd_done}, 3'b110);
            step();
        end
        bus.respcyc = 1'b0;
    endtask

    initial begin
        logic [511:0] l;
        logic [6:0]   s;
        logic         k;

        reset = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0; kind = 1'b0; addr = '0; wr_line = '0;
        bus.reqack = 1'b0; bus.resp = '0; bus.resptag = '0; bus.respcyc = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {busy, bus.reqcyc, bus.respack, rd_done, wr_done, tag_err}, 6'b0);
        chk("rst_rd_line", rd_line, '0);
        chk("rst_req", {bus.reqtag, bus.req}, '0);
        chk("rst_state", dbg_state, S_IDLE);
        step();
        reset = 1'b0;

        // Read, immediate handshakes; rd_done lands 10 cycles after the command cycle.
        send_cmd(1'b1, 1'b0, 64'h1234_5678, DATA, '0, 64'h1234_5640, 13'h1180,
                 {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0});
        run_req(1, 0, 0, 0, 0);
        run_resp({64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0}, 1'b0, 99, 0);
        @(negedge clk);
        chk("rd_done_latency", {rd_done, 32'(cyc_cnt - cmd_cyc)}, {1'b1, 32'd10});
        step();

        // Write with the address beat and data beat 4 each stalled three cycles.
        l = {64'h17, 64'h16, 64'h15, 64'h14, 64'h13, 64'h12, 64'h11, 64'h10};
        send_cmd(1'b0, 1'b1, 64'hABCD_00FF, DATA, l, 64'hABCD_00C0, 13'h0181, l);
        run_req(9, 0, 3, 5, 3);
        step();

        // Reset in the middle of a read, while response beat 3 is on the bus.
        send_cmd(1'b1, 1'b0, 64'h40, DATA, '0, 64'h40, 13'h1182, '0);
        run_req(1, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            bus.resp = 64'h40 + 64'(b); bus.resptag = cur_tag; bus.respcyc = 1'b1;
            @(negedge clk);
            chk("partial_ack", bus.respack, 1'b1);
            step();
        end
        bus.resp = 64'h43; bus.respcyc = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("async_rst_ctl", {busy, bus.reqcyc, bus.respack, rd_done, wr_done, tag_err}, 6'b0);
        chk("async_rst_line", rd_line, '0);
        chk("async_rst_req", {bus.reqtag, bus.req}, '0);
        exp_rd_q.delete();
        bus.respcyc = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Read and write together: read (seq 0) runs, held write (seq 1) follows on rd_done.
        send_cmd(1'b1, 1'b1, 64'h2000_0040, DATA, '0, 64'h2000_0040, 13'h1180,
                 {64'h27, 64'h26, 64'h25, 64'h24, 64'h23, 64'h22, 64'h21, 64'h20});
        run_req(1, 0, 0, 0, 0);
        run_resp({64'h27, 64'h26, 64'h25, 64'h24, 64'h23, 64'h22, 64'h21, 64'h20}, 1'b0, 4, 2);
        l = {64'h37, 64'h36, 64'h35, 64'h34, 64'h33, 64'h32, 64'h31, 64'h30};
        send_cmd(1'b0, 1'b1, 64'h3000_0001, INSTR, l, 64'h3000_0000, 13'h0101, l);
        run_req(9, 99, 0, 99, 0);
        step();

        // Wrong response tag on the first beat.
`ifdef CORE_REQ_TAGCHECK_EN
        l = {64'h5007, 64'h5006, 64'h5005, 64'h5004, 64'h5003, 64'h5002, 64'h5001, 64'h5000};
        send_cmd(1'b1, 1'b0, 64'h5000_0080, DATA, '0, 64'h5000_0080, 13'h1182, l);
        run_req(1, 0, 0, 0, 0);
        run_resp(l, 1'b1, 99, 0);
`else
        l = {64'h5006, 64'h5005, 64'h5004, 64'h5003, 64'h5002, 64'h5001, 64'h5000, 64'hBAD0_BAD0_BAD0_BAD0};
        send_cmd(1'b1, 1'b0, 64'h5000_0080, DATA, '0, 64'h5000_0080, 13'h1182, l);
        run_req(1, 0, 0, 0, 0);
        run_resp(l, 1'b1, 99, 0);
`endif

        // 130 back-to-back reads starting at seq 3, wrapping 127 -> 0.
        for (int i = 0; i < 130; i++) begin
            s = 7'(3 + i);
            k = (i % 2 == 1);
            for (int b = 0; b < 8; b++) l[64*b +: 64] = 64'(i * 16 + b);
            send_cmd(1'b1, 1'b0, 64'(i * 64 + 5), k, '0, 64'(i * 64), {1'b1, 4'b0001, k, s}, l);
            run_req(1, 0, 0, 0, 0);
            run_resp(l, 1'b0, 99, 0);
        end

        repeat (3) step();
        chk("queues_drained", {32'(exp_req_q.size()), 32'(exp_rd_q.size()),
                               32'(exp_wr_q.size()), 32'(exp_err_q.size())}, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
